mmio_bus_bridge: RTL and testbench

Bridge between the MicroBlaze MCS I/O bus and the MMIO slot array. It registers each I/O bus request, decodes it into a one-hot slot select plus shared read/write strobes, register address and write data, then returns read data with a single-cycle `io_ready`. It sits directly upstream of every MMIO slot (GPO, GPI, timers, UART).

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_bus_bridge_if.sv | 37 +++
 rtl/mmio_slot_decode.sv | 27 ++
 rtl/mmio_bus_bridge.sv | 154 +++++++++++++++
 tb/tb_mmio_bus_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MCS I/O bus to MMIO slot bridge.
// Address field layout, bus width, FSM states and the error word.
package mmio_pkg;

  localparam int DATA_W   = 32;
  localparam int SLOT_LSB = 7;
  localparam int SLOT_W   = 6;
  localparam int REG_LSB  = 2;
  localparam int REG_W    = 5;

  localparam logic [DATA_W-1:0] MMIO_ERR_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bridge_state_t;

endpackage

// File: rtl/mmio_bus_bridge_if.sv
// MicroBlaze MCS I/O bus bundle.
// master = MCS side, slave = bridge side.
interface mmio_bus_bridge_if;
  import mmio_pkg::*;

  logic              io_addr_strobe;
  logic              io_read_strobe;
  logic              io_write_strobe;
  logic [DATA_W-1:0] io_address;
  logic [DATA_W-1:0] io_write_data;
  logic [3:0]        io_byte_enable;
  logic [DATA_W-1:0] io_read_data;
  logic              io_ready;

  modport master (
    output io_addr_strobe,
    output io_read_strobe,
    output io_write_strobe,
    output io_address,
    output io_write_data,
    output io_byte_enable,
    input  io_read_data,
    input  io_ready
  );

  modport slave (
    input  io_addr_strobe,
    input  io_read_strobe,
    input  io_write_strobe,
    input  io_address,
    input  io_write_data,
    input  io_byte_enable,
    output io_read_data,
    output io_ready
  );

endinterface

// File: rtl/mmio_slot_decode.sv
// Address to one-hot slot select decoder.
// A slot is mapped only when the base byte matches and it exists.
module mmio_slot_decode
  import mmio_pkg::*;
#(
  parameter int          NUM_SLOTS = 64,
  parameter logic [7:0]  BASE_HI   = 8'hC0
) (
  input  logic [7:0]           base_i,
  input  logic [SLOT_W-1:0]    slot_i,
  output logic [NUM_SLOTS-1:0] cs_o,
  output logic                 mapped_o
);

  // Base match plus range check, then one-hot select
  always_comb begin
    mapped_o = (base_i == BASE_HI) &&
               ({1'b0, slot_i} < 7'(NUM_SLOTS));
    cs_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (mapped_o && slot_i == SLOT_W'(i)) begin
        cs_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// MCS I/O bus to MMIO slot array bridge, fixed 2-cycle latency.
// Optional MMIO_BUS_ERR_EN adds sticky err/err_addr tracking.
module mmio_bus_bridge
  import mmio_pkg::*;
#(
  parameter int         NUM_SLOTS = 64,
  parameter logic [7:0] BASE_HI   = 8'hC0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mmio_bus_bridge_if.slave     bus,
  output logic [NUM_SLOTS-1:0] slot_cs,
  output logic                 slot_read,
  output logic                 slot_write,
  output logic [REG_W-1:0]     slot_addr,
  output logic [DATA_W-1:0]    slot_write_data,
  input  logic [DATA_W-1:0]    slot_read_data [NUM_SLOTS]
`ifdef MMIO_BUS_ERR_EN
  ,
  output logic                 err,
  output logic [DATA_W-1:0]    err_addr
`endif
);

`ifdef MMIO_BUS_ERR_EN
  localparam logic [DATA_W-1:0] UNMAP_WORD = MMIO_ERR_WORD;
`else
  localparam logic [DATA_W-1:0] UNMAP_WORD = '0;
`endif

  bridge_state_t          state_q;
  logic [NUM_SLOTS-1:0]   cs_q;
  logic                   rd_q;
  logic                   wr_q;
  logic                   acc_wr_q;
  logic                   mapped_q;
  logic [REG_W-1:0]       reg_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   ready_q;
`ifdef MMIO_BUS_ERR_EN
  logic [DATA_W-1:0]      addr_q;
  logic                   err_q;
  logic [DATA_W-1:0]      err_addr_q;
`endif

  logic                   req;
  logic [NUM_SLOTS-1:0]   dec_cs;
  logic                   dec_mapped;
  logic [DATA_W-1:0]      rd_data_d;
  logic                   unused_bits;

  assign req = bus.io_addr_strobe &
               (bus.io_read_strobe | bus.io_write_strobe);

  assign unused_bits = ^{bus.io_byte_enable,
                         bus.io_address[23:13],
                         bus.io_address[1:0]};

  mmio_slot_decode #(
    .NUM_SLOTS (NUM_SLOTS),
    .BASE_HI   (BASE_HI)
  ) u_dec (
    .base_i   (bus.io_address[31:24]),
    .slot_i   (bus.io_address[SLOT_LSB +: SLOT_W]),
    .cs_o     (dec_cs),
    .mapped_o (dec_mapped)
  );

  // One-hot OR mux of the selected slot's read data
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cs_q[i]) begin
        rd_data_d = rd_data_d | slot_read_data[i];
      end
    end
  end

  // Bridge FSM: latch request, strobe slots for one cycle, respond
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cs_q     <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      acc_wr_q <= 1'b0;
      mapped_q <= 1'b0;
      reg_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
`ifdef MMIO_BUS_ERR_EN
      addr_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_q  <= ACCESS;
            cs_q     <= dec_cs;
            mapped_q <= dec_mapped;
            acc_wr_q <= bus.io_write_strobe;
            wr_q     <= bus.io_write_strobe & dec_mapped;
            rd_q     <= ~bus.io_write_strobe & dec_mapped;
            reg_q    <= bus.io_address[REG_LSB +: REG_W];
            wdata_q  <= bus.io_write_data;
`ifdef MMIO_BUS_ERR_EN
            addr_q   <= bus.io_address;
`endif
          end
        end
        ACCESS: begin
          state_q <= RESP;
          cs_q    <= '0;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          ready_q <= 1'b1;
          if (!acc_wr_q) begin
            rdata_q <= mapped_q ? rd_data_d : UNMAP_WORD;
          end
`ifdef MMIO_BUS_ERR_EN
          if (!mapped_q && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign slot_cs         = cs_q;
  assign slot_read       = rd_q;
  assign slot_write      = wr_q;
  assign slot_addr       = reg_q;
  assign slot_write_data = wdata_q;
  assign bus.io_read_data = rdata_q;
  assign bus.io_ready     = ready_q;
`ifdef MMIO_BUS_ERR_EN
  assign err      = err_q;
  assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Self-checking bench for mmio_bus_bridge (NUM_SLOTS=48).
// Expected values come from an address-rule model of the bridge.
module tb_mmio_bus_bridge;

  localparam int NS = 48;
`ifdef MMIO_BUS_ERR_EN
  localparam logic [31:0] UNMAP = 32'hDEADBEEF;
`else
  localparam logic [31:0] UNMAP = 32'h0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mmio_bus_bridge_if bus();

  logic [NS-1:0] slot_cs;
  logic          slot_read;
  logic          slot_write;
  logic [4:0]    slot_addr;
  logic [31:0]   slot_write_data;
  logic [31:0]   srd [NS];
`ifdef MMIO_BUS_ERR_EN
  logic          err;
  logic [31:0]   err_addr;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] exp_err_addr;

  mmio_bus_bridge #(.NUM_SLOTS(NS), .BASE_HI(8'hC0)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .slot_cs         (slot_cs),
    .slot_read       (slot_read),
    .slot_write      (slot_write),
    .slot_addr       (slot_addr),
    .slot_write_data (slot_write_data),
    .slot_read_data  (srd)
`ifdef MMIO_BUS_ERR_EN
    ,
    .err             (err),
    .err_addr        (err_addr)
`endif
  );

  task automatic bus_idle();
    bus.io_addr_strobe  = 1'b0;
    bus.io_read_strobe  = 1'b0;
    bus.io_write_strobe = 1'b0;
    bus.io_byte_enable  = 4'h0;
  endtask

  task automatic model_reset();
    exp_rdata    = '0;
    exp_err      = 1'b0;
    exp_err_addr = '0;
  endtask

  task automatic rand_srd();
    for (int i = 0; i < NS; i++) srd[i] = $urandom;
  endtask

  task automatic run_access(input logic [31:0] addr,
                            input logic [31:0] wdata,
                            input logic rd, input logic wr,
                            input string tag);
    logic [5:0]    slot;
    logic          mapped;
    logic [NS-1:0] ecs;
    logic          ewr;
    logic          erd;
    slot   = addr[12:7];
    mapped = (addr[31:24] == 8'hC0) && (int'(slot) < NS);
    ecs    = '0;
    if (mapped) ecs = {{(NS-1){1'b0}}, 1'b1} << slot;
    ewr    = wr & mapped;
    erd    = rd & ~wr & mapped;
    @(negedge clk);
    bus.io_addr_strobe  = 1'b1;
    bus.io_read_strobe  = rd;
    bus.io_write_strobe = wr;
    bus.io_address      = addr;
    bus.io_write_data   = wdata;
    bus.io_byte_enable  = 4'($urandom);
    @(posedge clk); #1;
    bus_idle();
    checks++;
    if ({slot_cs, slot_read, slot_write} !== {ecs, erd, ewr}) begin
      errors++;
      $display("FAIL %s strobes: got cs=%h r=%b w=%b exp cs=%h r=%b w=%b",
               tag, slot_cs, slot_read, slot_write, ecs, erd, ewr);
    end
    checks++;
    if ({slot_addr, slot_write_data} !== {addr[6:2], wdata}) begin
      errors++;
      $display("FAIL %s addr/data: got %h/%h exp %h/%h",
               tag, slot_addr, slot_write_data, addr[6:2], wdata);
    end
    checks++;
    if (bus.io_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s early_ready: got %b exp 0", tag, bus.io_ready);
    end
    if (rd && !wr) exp_rdata = mapped ? srd[slot] : UNMAP;
    if (!mapped && !exp_err) begin
      exp_err      = 1'b1;
      exp_err_addr = addr;
    end
    @(posedge clk); #1;
    checks++;
    if (bus.io_ready !== 1'b1 || bus.io_read_data !== exp_rdata) begin
      errors++;
      $display("FAIL %s resp: got rdy=%b data=%h exp rdy=1 data=%h",
               tag, bus.io_ready, bus.io_read_data, exp_rdata);
    end
    checks++;
    if ({slot_cs, slot_read, slot_write} !== '0 ||
        slot_addr !== addr[6:2]) begin
      errors++;
      $display("FAIL %s resp_idle: got cs=%h r=%b w=%b ra=%h exp 0 ra=%h",
               tag, slot_cs, slot_read, slot_write, slot_addr, addr[6:2]);
    end
`ifdef MMIO_BUS_ERR_EN
    checks++;
    if (err !== exp_err || err_addr !== exp_err_addr) begin
      errors++;
      $display("FAIL %s err: got %b/%h exp %b/%h",
               tag, err, err_addr, exp_err, exp_err_addr);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (bus.io_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_len: got %b exp 0", tag, bus.io_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_idle();
    bus.io_address    = '0;
    bus.io_write_data = '0;
    rand_srd();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({slot_cs, slot_read, slot_write} !== '0) begin
      errors++;
      $display("FAIL reset_strobes: got %h exp 0",
               {slot_cs, slot_read, slot_write});
    end
    checks++;
    if ({slot_addr, slot_write_data} !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h exp 0", {slot_addr, slot_write_data});
    end
    checks++;
    if ({bus.io_ready, bus.io_read_data} !== '0) begin
      errors++;
      $display("FAIL reset_resp: got %h exp 0", {bus.io_ready, bus.io_read_data});
    end
`ifdef MMIO_BUS_ERR_EN
    checks++;
    if ({err, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_err: got %h exp 0", {err, err_addr});
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write();
    run_access(32'hC000_0084, 32'hA5A5_0001, 1'b0, 1'b1, "write_s1");
  endtask

  task automatic test_read();
    srd[3] = 32'h1234_5678;
    run_access(32'hC000_0180, 32'h0, 1'b1, 1'b0, "read_s3");
    run_access(32'hC000_17FC, 32'h0, 1'b1, 1'b0, "read_s47");
  endtask

  task automatic test_rw_both();
    run_access(32'hC000_0008, 32'h0BAD_F00D, 1'b1, 1'b1, "rw_both");
  endtask

  task automatic test_unmapped();
    run_access(32'h8000_0000, 32'h0, 1'b1, 1'b0, "bad_base");
    run_access(32'h8000_0004, 32'h0, 1'b1, 1'b0, "bad_base2");
    run_access(32'hC000_1800, 32'h0, 1'b1, 1'b0, "slot_oor");
    run_access(32'hC000_1F84, 32'h55, 1'b0, 1'b1, "slot63_wr");
    run_access(32'hC0FF_E003, 32'h0, 1'b1, 1'b0, "ign_bits");
  endtask

  task automatic test_no_dir();
    int seen;
    seen = 0;
    @(negedge clk);
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'hC000_0100;
    @(negedge clk);
    bus_idle();
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.io_ready || slot_cs != '0 || slot_read || slot_write) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL no_dir: got %0d active cycles exp 0", seen);
    end
  endtask

  task automatic test_drop();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.io_addr_strobe  = 1'b1;
    bus.io_write_strobe = 1'b1;
    bus.io_address      = 32'hC000_0100;
    bus.io_write_data   = 32'h1111_2222;
    @(posedge clk); #1;
    bus.io_address      = 32'hC000_0280;
    bus.io_write_data   = 32'h3333_4444;
    checks++;
    if (slot_cs !== {{(NS-1){1'b0}}, 1'b1} << 2) begin
      errors++;
      $display("FAIL drop_first_cs: got %h exp bit 2", slot_cs);
    end
    @(posedge clk); #1;
    bus_idle();
    if (bus.io_ready) pulses++;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.io_ready) pulses++;
      if (slot_cs != '0) pulses += 10;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL drop_second: got %0d ready/strobe events exp 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.io_addr_strobe  = 1'b1;
    bus.io_read_strobe  = 1'b1;
    bus.io_address      = 32'hC000_0200;
    @(posedge clk); #1;
    bus_idle();
    checks++;
    if (slot_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_access: got read=%b exp 1", slot_read);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({slot_cs, slot_read, slot_write, slot_addr, slot_write_data,
         bus.io_ready, bus.io_read_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outs: got cs=%h r=%b ra=%h wd=%h rd=%h exp 0",
               slot_cs, slot_read, slot_addr, slot_write_data,
               bus.io_read_data);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.io_ready) pulses++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.io_ready) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_reset_ready: got %0d pulses exp 0", pulses);
    end
    srd[7] = 32'hCAFE_0007;
    run_access(32'hC000_0388, 32'h0, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [1:0]  dir;
    for (int n = 0; n < 40; n++) begin
      rand_srd();
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr[31:24] = 8'hC0;
      dir = 2'($urandom_range(1, 3));
      run_access(addr, $urandom, dir[0], dir[1], "random");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rw_both();
    test_unmapped();
    test_no_dir();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
